// File: rtl/vram_arbiter.sv
// Two-requester framebuffer arbiter: round-robin on ties, one outstanding
// transaction at a time, with an optional BUSY timeout that forces completion.
module vram_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_ni,

    input  logic              m0_sel_i,
    input  logic              m0_wr_i,
    input  logic [3:0]        m0_mask_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_sel_i,
    input  logic              m1_wr_i,
    input  logic [3:0]        m1_mask_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              fb_sel_o,
    output logic              fb_wr_o,
    output logic [3:0]        fb_mask_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [DATA_W-1:0] fb_data_o,
    input  logic              fb_ack_i,
    input  logic [DATA_W-1:0] fb_data_i,

    output logic              grant_o,
    output logic              timeout_err_o
);

    // Counter is sized so it can hold TIMEOUT_CYCLES itself; a zero timeout
    // still gets a 1-bit counter that is simply never compared.
    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam bit              TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_grant;
    logic                r_fb_sel;
    logic                r_fb_wr;
    logic [3:0]          r_fb_mask;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [DATA_W-1:0]   r_fb_data;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_data0;
    logic [DATA_W-1:0]   r_data1;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    state_t              w_state_nxt;
    logic                w_last_nxt;
    logic                w_grant_nxt;
    logic                w_fb_sel_nxt;
    logic                w_fb_wr_nxt;
    logic [3:0]          w_fb_mask_nxt;
    logic [ADDR_W-1:0]   w_fb_addr_nxt;
    logic [DATA_W-1:0]   w_fb_data_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;
    logic [DATA_W-1:0]   w_data0_nxt;
    logic [DATA_W-1:0]   w_data1_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_err_nxt;

    logic                w_req_any;
    logic                w_winner;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_cpl_data;

    assign w_req_any  = m0_sel_i | m1_sel_i;
    // On a tie the requester that did not complete last wins.
    assign w_winner   = (m0_sel_i & m1_sel_i) ? ~r_last_grant : m1_sel_i;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_timeout  = TO_EN && (w_cnt_inc == TO_VAL);
    assign w_cpl_data = fb_ack_i ? fb_data_i : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last_grant;
        w_grant_nxt   = r_grant;
        w_fb_sel_nxt  = r_fb_sel;
        w_fb_wr_nxt   = r_fb_wr;
        w_fb_mask_nxt = r_fb_mask;
        w_fb_addr_nxt = r_fb_addr;
        w_fb_data_nxt = r_fb_data;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_data0_nxt   = r_data0;
        w_data1_nxt   = r_data1;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_grant_nxt   = w_winner;
                    w_fb_sel_nxt  = 1'b1;
                    w_fb_wr_nxt   = w_winner ? m1_wr_i   : m0_wr_i;
                    w_fb_mask_nxt = w_winner ? m1_mask_i : m0_mask_i;
                    w_fb_addr_nxt = w_winner ? m1_addr_i : m0_addr_i;
                    w_fb_data_nxt = w_winner ? m1_data_i : m0_data_i;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // A real acknowledge on the timeout edge wins over the timeout.
                if (fb_ack_i || w_timeout) begin
                    w_fb_sel_nxt = 1'b0;
                    w_last_nxt   = r_grant;
                    w_state_nxt  = ST_DONE;
                    if (!fb_ack_i) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_grant) begin
                        w_ack1_nxt  = 1'b1;
                        w_data1_nxt = w_cpl_data;
                    end else begin
                        w_ack0_nxt  = 1'b1;
                        w_data0_nxt = w_cpl_data;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_fb_sel     <= 1'b0;
            r_fb_wr      <= 1'b0;
            r_fb_mask    <= '0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_grant      <= w_grant_nxt;
            r_fb_sel     <= w_fb_sel_nxt;
            r_fb_wr      <= w_fb_wr_nxt;
            r_fb_mask    <= w_fb_mask_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_data    <= w_fb_data_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_data0      <= w_data0_nxt;
            r_data1      <= w_data1_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign m0_ack_o      = r_ack0;
    assign m0_data_o     = r_data0;
    assign m1_ack_o      = r_ack1;
    assign m1_data_o     = r_data1;
    assign fb_sel_o      = r_fb_sel;
    assign fb_wr_o       = r_fb_wr;
    assign fb_mask_o     = r_fb_mask;
    assign fb_addr_o     = r_fb_addr;
    assign fb_data_o     = r_fb_data;
    assign grant_o       = r_grant;
    assign timeout_err_o = r_err;

endmodule
